// File: rtl/nand_cpu.sv
// rtl/nand_cpu.sv - single-cycle 8-bit NAND/ADD/ADC processor with internal instruction and data memories
module nand_imem (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [7:0]  raddr,
    output logic [15:0] rdata
);
    logic [15:0] core [0:255];

    always_ff @(posedge clk) begin
        if (we) core[waddr] <= wdata;
    end

    assign rdata = core[raddr];
endmodule

module nand_dmem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);
    logic [7:0] core [0:255];

    always_ff @(posedge clk) begin
        if (we) core[addr] <= wdata;
    end

    assign rdata = core[addr];
endmodule

module nand_cpu (
    input  logic clk,
    input  logic n_rst,
    output logic halt
);
    localparam logic [3:0] OP_NAND = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_ADC  = 4'h2;
    localparam logic [3:0] OP_LI   = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_BZ   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [7:0]  pc;
    logic [7:0]  r [0:7];
    logic        c;

    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic [7:0]  imm;
    logic [7:0]  rd_val, rs_val, rt_val;
    logic [8:0]  sum;
    logic [7:0]  dm_rdata;

    logic [7:0]  pc_next;
    logic        c_next;
    logic        halt_next;
    logic        rf_we;
    logic [7:0]  rf_wdata;
    logic        dm_we;

    nand_imem I_MEM (
        .clk   (clk),
        .we    (1'b0),
        .waddr (8'h00),
        .wdata (16'h0000),
        .raddr (pc),
        .rdata (instr)
    );

    // Stores are suppressed in reset and once halted so memory stays frozen with the core.
    nand_dmem D_MEM (
        .clk   (clk),
        .we    (dm_we & ~halt & ~n_rst),
        .addr  (rs_val),
        .wdata (rd_val),
        .rdata (dm_rdata)
    );

    always_comb begin
        op        = instr[15:12];
        rd        = instr[11:9];
        rs        = instr[8:6];
        rt        = instr[5:3];
        imm       = instr[7:0];
        rd_val    = r[rd];
        rs_val    = r[rs];
        rt_val    = r[rt];
        sum       = {1'b0, rs_val} + {1'b0, rt_val} + {8'h00, (op == OP_ADC) & c};
        pc_next   = pc + 8'd1;
        c_next    = c;
        halt_next = halt;
        rf_we     = 1'b0;
        rf_wdata  = 8'h00;
        dm_we     = 1'b0;
        case (op)
            OP_NAND: begin rf_we = 1'b1; rf_wdata = ~(rs_val & rt_val); end
            OP_ADD,
            OP_ADC:  begin rf_we = 1'b1; rf_wdata = sum[7:0]; c_next = sum[8]; end
            OP_LI:   begin rf_we = 1'b1; rf_wdata = imm; end
            OP_LD:   begin rf_we = 1'b1; rf_wdata = dm_rdata; end
            OP_ST:   dm_we = 1'b1;
            OP_BZ:   if (rd_val == 8'h00) pc_next = imm;
            OP_JMP:  pc_next = imm;
            OP_HALT: begin halt_next = 1'b1; pc_next = pc; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            pc   <= 8'h00;
            c    <= 1'b0;
            halt <= 1'b0;
            for (int i = 0; i < 8; i++) r[i] <= 8'h00;
        end else if (!halt) begin
            pc   <= pc_next;
            c    <= c_next;
            halt <= halt_next;
            if (rf_we) r[rd] <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_nand_cpu.sv
// tb/tb_nand_cpu.sv - self-checking bench for nand_cpu with arithmetic reference model
module tb_nand_cpu;
    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic halt;
    int   checks = 0;
    int   errors = 0;

    nand_cpu dut (
        .clk   (clk),
        .n_rst (n_rst),
        .halt  (halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rrr(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.I_MEM.core[i] = 16'hF000;
    endtask

    task automatic load_add_prog();
        logic [15:0] p [0:14];
        p[0]  = ri(4'h3, 3'd4, 8'd0);
        p[1]  = ri(4'h3, 3'd5, 8'd1);
        p[2]  = ri(4'h3, 3'd6, 8'd2);
        p[3]  = ri(4'h3, 3'd7, 8'd3);
        p[4]  = rrr(4'h4, 3'd0, 3'd4, 3'd0);
        p[5]  = rrr(4'h4, 3'd1, 3'd5, 3'd0);
        p[6]  = rrr(4'h4, 3'd2, 3'd6, 3'd0);
        p[7]  = rrr(4'h4, 3'd3, 3'd7, 3'd0);
        p[8]  = rrr(4'h1, 3'd0, 3'd0, 3'd2);
        p[9]  = rrr(4'h2, 3'd1, 3'd1, 3'd3);
        p[10] = ri(4'h3, 3'd4, 8'd4);
        p[11] = ri(4'h3, 3'd5, 8'd5);
        p[12] = rrr(4'h5, 3'd0, 3'd4, 3'd0);
        p[13] = rrr(4'h5, 3'd1, 3'd5, 3'd0);
        p[14] = 16'hF000;
        clear_imem();
        for (int i = 0; i < 15; i++) dut.I_MEM.core[i] = p[i];
    endtask

    task automatic load_branch_prog(input logic [7:0] a, input logic [7:0] b);
        clear_imem();
        dut.I_MEM.core[0]  = ri(4'h3, 3'd1, a);
        dut.I_MEM.core[1]  = ri(4'h3, 3'd2, b);
        dut.I_MEM.core[2]  = rrr(4'h0, 3'd3, 3'd1, 3'd2);
        dut.I_MEM.core[3]  = ri(4'h6, 3'd0, 8'd6);
        dut.I_MEM.core[4]  = ri(4'h3, 3'd4, 8'h11);
        dut.I_MEM.core[5]  = 16'hF000;
        dut.I_MEM.core[6]  = ri(4'h6, 3'd3, 8'd9);
        dut.I_MEM.core[7]  = ri(4'h3, 3'd5, 8'h77);
        dut.I_MEM.core[8]  = 16'hF000;
        dut.I_MEM.core[9]  = ri(4'h3, 3'd6, 8'h99);
        dut.I_MEM.core[10] = 16'hF000;
    endtask

    task automatic set_operands(input logic [15:0] op0, input logic [15:0] op1);
        dut.D_MEM.core[0] = op0[7:0];
        dut.D_MEM.core[1] = op0[15:8];
        dut.D_MEM.core[2] = op1[7:0];
        dut.D_MEM.core[3] = op1[15:8];
        dut.D_MEM.core[4] = 8'h00;
        dut.D_MEM.core[5] = 8'h00;
    endtask

    task automatic do_reset(input int edges);
        @(negedge clk) n_rst = 1'b1;
        repeat (edges) @(posedge clk);
        @(negedge clk) n_rst = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halt && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_add(input string tag, input logic [15:0] op0, input logic [15:0] op1);
        logic [16:0] model;
        model = {1'b0, op0} + {1'b0, op1};
        check({tag, "_sum"}, {dut.D_MEM.core[5], dut.D_MEM.core[4]}, model[15:0]);
        check({tag, "_c"}, dut.c, model[16]);
        check({tag, "_halt"}, halt, 1'b1);
    endtask

    initial begin
        int          cyc;
        logic [15:0] op0, op1, sum;
        logic [7:0]  a, b, nd;
        logic [7:0]  pc_hold;

        // Basic 16-bit add with halt latency and post-halt freeze
        load_add_prog();
        set_operands(16'h12F0, 16'h0F20);
        do_reset(2);
        run_to_halt(cyc);
        check("add_cycles", cyc, 15);
        check_add("add", 16'h12F0, 16'h0F20);
        check("add_core4", dut.D_MEM.core[4], 8'h10);
        check("add_core5", dut.D_MEM.core[5], 8'h22);
        check("add_pc", dut.pc, 8'd14);
        pc_hold = dut.pc;
        dut.D_MEM.core[4] = 8'h5A;
        repeat (5) @(posedge clk);
        #1;
        check("freeze_pc", dut.pc, pc_hold);
        check("freeze_halt", halt, 1'b1);
        check("freeze_r0", dut.r[0], 8'h10);
        check("freeze_dmem", dut.D_MEM.core[4], 8'h5A);

        // Reset clears architectural state, leaves memory alone
        dut.D_MEM.core[7] = 8'hA5;
        do_reset(2);
        check("rst_pc", dut.pc, 8'h00);
        check("rst_halt", halt, 1'b0);
        check("rst_c", dut.c, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), dut.r[i], 8'h00);
        check("rst_dmem7", dut.D_MEM.core[7], 8'hA5);
        check("rst_imem0", dut.I_MEM.core[0], ri(4'h3, 3'd4, 8'd0));

        // Carry out of the high byte
        set_operands(16'hFFFF, 16'h0001);
        do_reset(2);
        run_to_halt(cyc);
        check_add("wrap", 16'hFFFF, 16'h0001);

        // NAND and branch, directed then random
        for (int k = 0; k < 6; k++) begin
            if (k == 0)      begin a = 8'hF0; b = 8'h3C; end
            else if (k == 1) begin a = 8'hFF; b = 8'hFF; end
            else             begin a = 8'($urandom); b = 8'($urandom); end
            nd = ~(a & b);
            load_branch_prog(a, b);
            do_reset(2);
            run_to_halt(cyc);
            if (k == 0) check("nand_f0_3c", dut.r[3], 8'hCF);
            check($sformatf("br%0d_r3", k), dut.r[3], nd);
            check($sformatf("br%0d_r4", k), dut.r[4], 8'h00);
            check($sformatf("br%0d_pc", k), dut.pc, (nd == 8'h00) ? 8'd10 : 8'd8);
            check($sformatf("br%0d_r5", k), dut.r[5], (nd == 8'h00) ? 8'h00 : 8'h77);
            check($sformatf("br%0d_r6", k), dut.r[6], (nd == 8'h00) ? 8'h99 : 8'h00);
        end

        // Randomised sums with a 40 ns reset pulse each time
        load_add_prog();
        for (int k = 0; k < 64; k++) begin
            sum = 16'($urandom);
            op0 = 16'($urandom);
            op1 = sum - op0;
            set_operands(op0, op1);
            do_reset(4);
            run_to_halt(cyc);
            check($sformatf("rnd%0d_sum", k), {dut.D_MEM.core[5], dut.D_MEM.core[4]}, sum);
            check_add($sformatf("rnd%0d", k), op0, op1);
        end

        // Reset in the middle of a run restarts cleanly
        op0 = 16'h8421;
        op1 = 16'h7BDF;
        set_operands(op0, op1);
        do_reset(2);
        repeat (6) @(posedge clk);
        #1;
        check("mid_running", halt, 1'b0);
        do_reset(2);
        check("mid_pc", dut.pc, 8'h00);
        check("mid_halt", halt, 1'b0);
        check("mid_r0", dut.r[0], 8'h00);
        check("mid_dmem0", dut.D_MEM.core[0], op0[7:0]);
        check("mid_dmem3", dut.D_MEM.core[3], op1[15:8]);
        run_to_halt(cyc);
        check("mid_cycles", cyc, 15);
        check_add("mid", op0, op1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
